result_drain: RTL
=================

Name: result_drain

Overview:
- Downstream of the multicycle RISC-V core.
- Once the core asserts done, it reads the result-matrix region of the byte-wide data memory through a synchronous read port. It packs each 4 bytes into a 32-bit word and streams the words out on a valid/ready interface.
- It then emits one trailer word holding the core's cycle and instruction counts, captured at the trigger cycle.
- It feeds host readout logic (UART/LED/testbench) so results are visible without hierarchical peeks.

Parameters:
- ROWS, 3, matrix A rows
- COLS, 4, matrix A cols / vector rows
- COLS2, 1, result cols
- RESULT_BASE, ROWS*COLS*4+COLS*COLS2*4, byte address of the first result byte
- NUM_WORDS, ROWS*COLS2, result words to drain
- ADDR_W, 8, data-memory byte address width

Ports:
- CLOCK_50  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- done  in  1  core program-complete flag (level)
- clock_count  in  16  core cycle counter
- instr_cnt  in  16  core instruction counter
- mem_addr  out  ADDR_W  data-memory byte read address
- mem_rdata  in  8  byte read data, valid one cycle after mem_addr
- out_data  out  32  streamed word
- out_valid  out  1  out_data valid
- out_ready  in  1  sink accepts when high with out_valid
- out_last  out  1  high with the trailer word
- busy  out  1  drain in progress
- finished  out  1  drain complete, held until done drops

Behaviour:
- Reset (async, rst_n=0): state=IDLE.
  - Outputs to 0: out_valid, out_last, busy, finished, mem_addr, out_data.
  - Word counter, byte counter and captured counts cleared.
  - Takes effect immediately, including mid-drain. Any partially assembled word is discarded.
- States: IDLE, FETCH, HOLD, TRAIL, FIN.
- IDLE → FETCH: on the first rising edge with done=1.
  - Same edge: latch {clock_count, instr_cnt} into a 32-bit capture register; word idx k=0, byte idx j=0; busy=1.
- FETCH, byte addressing:
  - Drives mem_addr = RESULT_BASE + 4k + j for j=0..3 on consecutive cycles.
  - Byte returned one cycle later is shifted in MSB-first: the lowest address is bits[31:24]. This matches the core's store order.
  - Address arithmetic is modulo 2^ADDR_W; no bounds error.
- FETCH → HOLD: 5 cycles after FETCH entry, when the 4th byte is captured.
  - out_data = assembled word, out_valid=1.
- HOLD:
  - out_data and out_valid are held stable while out_ready=0.
  - A transfer occurs on an edge where out_valid&out_ready=1.
  - After a transfer, if k<NUM_WORDS-1: k++, j=0, out_valid=0, → FETCH. No bubble-free back-to-back; one word per ≥6 cycles.
  - If k=NUM_WORDS-1: → TRAIL.
- TRAIL:
  - out_data = capture register, out_valid=1, out_last=1.
  - On transfer: out_valid=0, out_last=0, busy=0, finished=1, → FIN.
- FIN:
  - Stays while done=1.
  - When done=0: finished=0, → IDLE, re-armed for the next program.
- done dropping during FETCH/HOLD/TRAIL is ignored; the drain completes.
- clock_count and instr_cnt changes after capture are ignored.
- out_ready high in IDLE or FETCH has no effect. out_valid never asserts outside HOLD/TRAIL.
- NUM_WORDS=0: only the trailer is sent (IDLE → TRAIL directly, one cycle after trigger).
- mem_addr is 0 whenever not in FETCH.

Test Plan:
- Default params; preload bytes at addresses 64..75 = 00 00 00 1E, 00 00 00 46, FF FF FF F6; pulse done=1 with clock_count=0x0123, instr_cnt=0x0040; out_ready=1 → out_data 0x0000001E, 0x00000046, 0xFFFFFFF6, then 0x01230040 with out_last=1; finished=1; first out_valid 5 cycles after trigger edge.
- Same stimulus, out_ready held 0 for 10 cycles per word → out_data/out_valid stable throughout each stall; word order and values unchanged; no extra words.
- Assert rst_n=0 mid-FETCH of word 1 → out_valid/busy drop immediately; after release and a new done rise, the full sequence restarts from word 0.
- done held high after finish, then dropped and raised again with clock_count=0x0200 → no output until done falls; second drain repeats the data with trailer 0x02000040.
- done deasserted during HOLD of word 0 → all 3 words + trailer still delivered; finished then clears on the next cycle since done=0.
- ROWS=1, COLS2=0 → only trailer word, out_last=1, one cycle after trigger; mem_addr stays 0.

Source files
------------

// File: rtl/result_drain.sv
// result_drain: once the core reports done, this block reads the result-matrix
// bytes out of data memory and packs every 4 bytes (lowest address in the MSBs)
// into a 32-bit word. It streams those words on a valid/ready port and then sends
// one trailer word {clock_count, instr_cnt}, captured on the trigger edge.
module result_drain #(
  parameter int ROWS        = 3,
  parameter int COLS        = 4,
  parameter int COLS2       = 1,
  parameter int RESULT_BASE = ROWS*COLS*4 + COLS*COLS2*4,
  parameter int NUM_WORDS   = ROWS*COLS2,
  parameter int ADDR_W      = 8
) (
  input  logic              CLOCK_50,
  input  logic              rst_n,
  input  logic              done,
  input  logic [15:0]       clock_count,
  input  logic [15:0]       instr_cnt,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [31:0]       out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              finished
);

  localparam int KW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [ADDR_W-1:0] BASE_A    = ADDR_W'(RESULT_BASE);
  localparam logic [KW-1:0]     LAST_WORD = KW'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    HOLD  = 3'd2,
    TRAIL = 3'd3,
    FIN   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [KW-1:0]     k_q, k_d;           // word index
  logic [2:0]        j_q, j_d;           // FETCH cycle / byte index (0..4)
  logic [ADDR_W-1:0] wbase_q, wbase_d;   // byte address of byte 0 of word k
  logic [23:0]       shift_q, shift_d;   // first three bytes of the word being assembled
  logic [31:0]       cap_q, cap_d;       // {clock_count, instr_cnt} at trigger
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              busy_q, busy_d;
  logic              finished_q, finished_d;
  logic              xfer_s;

  assign xfer_s    = out_valid_q & out_ready;
  assign mem_addr  = mem_addr_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign finished  = finished_q;

  // Next-state and registered-output logic for the drain sequencer.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    j_d         = j_q;
    wbase_d     = wbase_q;
    shift_d     = shift_q;
    cap_d       = cap_q;
    mem_addr_d  = {ADDR_W{1'b0}};
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    finished_d  = finished_q;

    case (state_q)
      IDLE: begin
        if (done) begin
          cap_d   = {clock_count, instr_cnt};
          k_d     = {KW{1'b0}};
          j_d     = 3'd0;
          wbase_d = BASE_A;
          busy_d  = 1'b1;
          if (NUM_WORDS == 0) begin
            // Nothing to read: present the trailer straight away.
            state_d     = TRAIL;
            out_data_d  = {clock_count, instr_cnt};
            out_valid_d = 1'b1;
            out_last_d  = 1'b1;
          end else begin
            state_d    = FETCH;
            mem_addr_d = BASE_A;
          end
        end else begin
          state_d = IDLE;
        end
      end

      FETCH: begin
        // Addresses go out on j=0..3; read data lags one cycle, so bytes land on j=1..4.
        if (j_q < 3'd3) begin
          mem_addr_d = wbase_q + ADDR_W'(j_q + 3'd1);
        end else begin
          mem_addr_d = {ADDR_W{1'b0}};
        end
        if (j_q == 3'd4) begin
          out_data_d  = {shift_q, mem_rdata};
          out_valid_d = 1'b1;
          out_last_d  = 1'b0;
          j_d         = 3'd0;
          state_d     = HOLD;
        end else if (j_q != 3'd0) begin
          shift_d = {shift_q[15:0], mem_rdata};
          j_d     = j_q + 3'd1;
        end else begin
          j_d = j_q + 3'd1;
        end
      end

      HOLD: begin
        if (xfer_s) begin
          if (k_q == LAST_WORD) begin
            state_d     = TRAIL;
            out_data_d  = cap_q;
            out_valid_d = 1'b1;
            out_last_d  = 1'b1;
          end else begin
            state_d     = FETCH;
            out_valid_d = 1'b0;
            k_d         = k_q + {{(KW-1){1'b0}}, 1'b1};
            j_d         = 3'd0;
            wbase_d     = wbase_q + ADDR_W'(4);
            mem_addr_d  = wbase_q + ADDR_W'(4);
          end
        end else begin
          state_d = HOLD;
        end
      end

      TRAIL: begin
        if (xfer_s) begin
          state_d     = FIN;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          busy_d      = 1'b0;
          finished_d  = 1'b1;
        end else begin
          state_d = TRAIL;
        end
      end

      FIN: begin
        // Wait for the core to drop done so that one program gives exactly one drain.
        if (!done) begin
          state_d    = IDLE;
          finished_d = 1'b0;
        end else begin
          state_d = FIN;
        end
      end

      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        busy_d      = 1'b0;
        finished_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset discards any partially assembled word.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= {KW{1'b0}};
      j_q         <= 3'd0;
      wbase_q     <= {ADDR_W{1'b0}};
      shift_q     <= 24'd0;
      cap_q       <= 32'd0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      out_data_q  <= 32'd0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      finished_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      j_q         <= j_d;
      wbase_q     <= wbase_d;
      shift_q     <= shift_d;
      cap_q       <= cap_d;
      mem_addr_q  <= mem_addr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      finished_q  <= finished_d;
    end
  end

endmodule
